// File: rtl/pch_carry_unit.sv
// ---------------------------------------------------------------------------
// pch_carry_unit
// Program-counter high byte for the 65C02 core. This is the consuming end of
// the PCL->PCH carry handshake. PCH can also be loaded from the data bus or
// with the vector page, and it is driven onto both the address and data buses.
//
// Ports
//   fclk                  core clock, all state on the rising edge
//   rst                   asynchronous active-high reset
//   instruction_decode_in load PCH from db_in (JMP/JSR/RTS high byte)
//   db_in[7:0]            data bus in
//   db_out[7:0]           PCH onto the data bus (pushes)
//   address_high_out[7:0] PCH onto the address bus high byte
//   push_resb/irqb/nmib   load VECTOR_PAGE
//   carry_to_pch          level carry request from PCL
//   carry_done            one-cycle acknowledge to PCL
//   pc_stall              high while a carry is pending or unacknowledged
//   pc_wrap               one-cycle pulse after PCH wraps (FF->00 or 00->FF)
//   branch_fix_req/dir    branch page-cross fixup (dir 1 = +1, 0 = -1)
//
// Build option
//   BRANCH_FIXUP_EN  when defined, enables the branch page-cross fixup path.
//                    When undefined, branch_fix_req/branch_fix_dir are ignored.
//
// state | meaning
// IDLE  | no carry in flight; a high carry_to_pch is taken on the next edge
// ACK   | carry taken; carry_done is high for exactly this cycle
// HOLD  | carry already serviced; wait for carry_to_pch to fall
// ---------------------------------------------------------------------------
module pch_carry_unit #(
    parameter logic [7:0] VECTOR_PAGE = 8'hFF,
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       instruction_decode_in,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic [7:0] address_high_out,
    input  logic       push_resb,
    input  logic       push_irqb,
    input  logic       push_nmib,
    input  logic       carry_to_pch,
    output logic       carry_done,
    output logic       pc_stall,
    output logic       pc_wrap,
    input  logic       branch_fix_req,
    input  logic       branch_fix_dir
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pch_q, pch_d;
    logic       wrap_q, wrap_d;
    logic       vector_load;

    assign vector_load = push_resb | push_irqb | push_nmib;

    // State and datapath registers
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pch_q   <= RESET_VALUE;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pch_q   <= pch_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next state: the carry is acknowledged even when a load overrides the
    // increment, so PCL never waits forever.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = carry_to_pch ? ACK  : IDLE;
            ACK:     state_d = carry_to_pch ? HOLD : IDLE;
            HOLD:    state_d = carry_to_pch ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // PCH update with fixed priority: decode load > vector > carry > fixup.
    always_comb begin
        pch_d  = pch_q;
        wrap_d = 1'b0;
        if (instruction_decode_in) begin
            pch_d = db_in;
        end else if (vector_load) begin
            pch_d = VECTOR_PAGE;
        end else if (state_q == IDLE && carry_to_pch) begin
            pch_d  = pch_q + 8'd1;
            wrap_d = (pch_q == 8'hFF);
        end
`ifdef BRANCH_FIXUP_EN
        // Fixup only in a quiet IDLE cycle; otherwise the decoder reissues it.
        else if (state_q == IDLE && branch_fix_req) begin
            if (branch_fix_dir) begin
                pch_d  = pch_q + 8'd1;
                wrap_d = (pch_q == 8'hFF);
            end else begin
                pch_d  = pch_q - 8'd1;
                wrap_d = (pch_q == 8'h00);
            end
        end
`endif
    end

`ifndef BRANCH_FIXUP_EN
    logic unused_fix;
    assign unused_fix = branch_fix_req ^ branch_fix_dir;
`endif

    // Outputs
    always_comb begin
        carry_done = (state_q == ACK);
        pc_stall   = ((state_q == IDLE) && carry_to_pch) || (state_q == ACK);
    end

    assign pc_wrap          = wrap_q;
    assign db_out           = pch_q;
    assign address_high_out = pch_q;

endmodule

// File: tb/tb_pch_carry_unit.sv
module tb_pch_carry_unit;

    logic       fclk = 1'b0;
    logic       rst;
    logic       instruction_decode_in;
    logic [7:0] db_in;
    logic [7:0] db_out;
    logic [7:0] address_high_out;
    logic       push_resb, push_irqb, push_nmib;
    logic       carry_to_pch;
    logic       carry_done;
    logic       pc_stall;
    logic       pc_wrap;
    logic       branch_fix_req, branch_fix_dir;

    int checks = 0;
    int errors = 0;

    always #5 fclk = ~fclk;

    pch_carry_unit dut (
        .fclk                  (fclk),
        .rst                   (rst),
        .instruction_decode_in (instruction_decode_in),
        .db_in                 (db_in),
        .db_out                (db_out),
        .address_high_out      (address_high_out),
        .push_resb             (push_resb),
        .push_irqb             (push_irqb),
        .push_nmib             (push_nmib),
        .carry_to_pch          (carry_to_pch),
        .carry_done            (carry_done),
        .pc_stall              (pc_stall),
        .pc_wrap               (pc_wrap),
        .branch_fix_req        (branch_fix_req),
        .branch_fix_dir        (branch_fix_dir)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before checking.
    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] pch, input logic done,
                             input logic stall, input logic wrap);
        chk({tag, ".pch"},   address_high_out, pch);
        chk({tag, ".db"},    db_out,           pch);
        chk({tag, ".done"},  {7'd0, carry_done}, {7'd0, done});
        chk({tag, ".stall"}, {7'd0, pc_stall},   {7'd0, stall});
        chk({tag, ".wrap"},  {7'd0, pc_wrap},    {7'd0, wrap});
    endtask

    task automatic load(input logic [7:0] v);
        instruction_decode_in = 1'b1;
        db_in = v;
        tick();
        instruction_decode_in = 1'b0;
        db_in = 8'h00;
    endtask

    initial begin
        rst = 1'b1;
        instruction_decode_in = 1'b0;
        db_in = 8'h00;
        push_resb = 1'b0; push_irqb = 1'b0; push_nmib = 1'b0;
        carry_to_pch = 1'b0;
        branch_fix_req = 1'b0; branch_fix_dir = 1'b0;

        // 1: reset
        repeat (3) @(posedge fclk);
        #1 chk_state("rst_held", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge fclk) rst = 1'b0;
        tick();
        chk_state("rst_rel", 8'h00, 1'b0, 1'b0, 1'b0);

        // 2: carry held three cycles gives exactly one increment
        load(8'h12);
        chk("ld12", address_high_out, 8'h12);
        carry_to_pch = 1'b1;
        #1 chk_state("c2_req", 8'h12, 1'b0, 1'b1, 1'b0);
        tick();
        chk_state("c2_ack", 8'h13, 1'b1, 1'b1, 1'b0);
        tick();
        chk_state("c2_hold1", 8'h13, 1'b0, 1'b0, 1'b0);
        tick();
        chk_state("c2_hold2", 8'h13, 1'b0, 1'b0, 1'b0);
        carry_to_pch = 1'b0;
        tick();
        chk_state("c2_idle", 8'h13, 1'b0, 1'b0, 1'b0);

        // 3: wrap FF->00
        load(8'hFF);
        carry_to_pch = 1'b1;
        tick();
        carry_to_pch = 1'b0;
        chk_state("c3_wrap", 8'h00, 1'b1, 1'b1, 1'b1);
        tick();
        chk_state("c3_after", 8'h00, 1'b0, 1'b0, 1'b0);

        // 4: decode load with carry on the same edge: load wins, still acked
        instruction_decode_in = 1'b1;
        db_in = 8'hA5;
        carry_to_pch = 1'b1;
        tick();
        instruction_decode_in = 1'b0;
        carry_to_pch = 1'b0;
        chk_state("c4_ld", 8'hA5, 1'b1, 1'b1, 1'b0);
        tick();
        chk_state("c4_after", 8'hA5, 1'b0, 1'b0, 1'b0);

        // decode load beats vector
        instruction_decode_in = 1'b1;
        db_in = 8'h33;
        push_resb = 1'b1;
        tick();
        instruction_decode_in = 1'b0;
        push_resb = 1'b0;
        chk("prio_ld", address_high_out, 8'h33);

        // 5: two vector requests at once -> vector page
        push_nmib = 1'b1;
        push_irqb = 1'b1;
        tick();
        push_nmib = 1'b0;
        push_irqb = 1'b0;
        chk("c5_vec", address_high_out, 8'hFF);

        // reset in the middle of ACK
        load(8'h40);
        carry_to_pch = 1'b1;
        tick();
        chk_state("c5_ack", 8'h41, 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 chk_state("c5_rst", 8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge fclk) rst = 1'b0;
        tick();
        chk_state("c5_newreq", 8'h01, 1'b1, 1'b1, 1'b0);
        carry_to_pch = 1'b0;
        tick();
        chk_state("c5_idle", 8'h01, 1'b0, 1'b0, 1'b0);

        // 6: branch fixup
        load(8'h00);
        branch_fix_req = 1'b1;
        branch_fix_dir = 1'b0;
        tick();
        branch_fix_req = 1'b0;
`ifdef BRANCH_FIXUP_EN
        chk_state("c6_dec", 8'hFF, 1'b0, 1'b0, 1'b1);
        branch_fix_req = 1'b1;
        branch_fix_dir = 1'b1;
        tick();
        branch_fix_req = 1'b0;
        chk_state("c6_inc", 8'h00, 1'b0, 1'b0, 1'b1);
        // fixup alongside a carry is dropped: only the carry increments
        branch_fix_req = 1'b1;
        carry_to_pch = 1'b1;
        tick();
        branch_fix_req = 1'b0;
        carry_to_pch = 1'b0;
        chk_state("c6_drop", 8'h01, 1'b1, 1'b1, 1'b0);
`else
        chk_state("c6_off", 8'h00, 1'b0, 1'b0, 1'b0);
        branch_fix_req = 1'b1;
        branch_fix_dir = 1'b1;
        tick();
        branch_fix_req = 1'b0;
        chk_state("c6_off_inc", 8'h00, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
